// File: rtl/stream_arbiter_qos_aging_if.sv
// Stream bundle for stream_arbiter_qos_aging: N producer streams in, one sink stream out.
// Modports:
//   master - the arbiter: consumes s_* payload/valid and m_ready_in, drives s_ready_out and m_*.
//   slave  - the environment: drives producer streams and downstream ready, observes the rest.
// Per-stream signals are packed arrays indexed by stream number.
interface stream_arbiter_qos_aging_if #(
  parameter int unsigned T_DATA_WIDTH = 8,
  parameter int unsigned T_QOS__WIDTH = 4,
  parameter int unsigned STREAM_COUNT = 4,
  parameter int unsigned T_ID___WIDTH = $clog2(STREAM_COUNT)
);
  logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_in;
  logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0] s_qos_in;
  logic [STREAM_COUNT-1:0]                   s_last_in;
  logic [STREAM_COUNT-1:0]                   s_valid_in;
  logic [STREAM_COUNT-1:0]                   s_ready_out;
  logic [T_DATA_WIDTH-1:0]                   m_data_out;
  logic [T_QOS__WIDTH-1:0]                   m_qos_out;
  logic [T_ID___WIDTH-1:0]                   m_id_out;
  logic                                      m_last_out;
  logic                                      m_valid_out;
  logic                                      m_ready_in;

  modport master (
    input  s_data_in, s_qos_in, s_last_in, s_valid_in, m_ready_in,
    output s_ready_out, m_data_out, m_qos_out, m_id_out, m_last_out, m_valid_out
  );

  modport slave (
    output s_data_in, s_qos_in, s_last_in, s_valid_in, m_ready_in,
    input  s_ready_out, m_data_out, m_qos_out, m_id_out, m_last_out, m_valid_out
  );
endinterface

// File: rtl/stream_arbiter_qos_aging.sv
// Packet-level N:1 stream arbiter with QoS priority, round-robin tie-break and optional
// anti-starvation aging.
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset
//   bus    - stream_arbiter_qos_aging_if.master: s_data/qos/last/valid_in, s_ready_out,
//            m_data/qos/id/last/valid_out, m_ready_in
// Operation: IDLE picks a winner (urgent > higher QoS > round-robin from rr_ptr) and latches
// its id and QoS; BUSY passes the granted stream through with zero latency until the last
// beat handshakes, then returns to IDLE (one bubble cycle per packet).
// Optional macro STREAM_ARB_AGING_EN: builds per-stream wait counters; a stream that has lost
// AGE_LIMIT arbitrations becomes urgent. Without it, selection is QoS then round-robin only.
module stream_arbiter_qos_aging #(
  parameter int unsigned T_DATA_WIDTH = 8,
  parameter int unsigned T_QOS__WIDTH = 4,
  parameter int unsigned STREAM_COUNT = 4,
  parameter int unsigned T_ID___WIDTH = $clog2(STREAM_COUNT),
  parameter int unsigned AGE_WIDTH    = 4,
  parameter int unsigned AGE_LIMIT    = 8
) (
  input logic                          clk,
  input logic                          rst_n,
  stream_arbiter_qos_aging_if.master   bus
);

  localparam int unsigned KeyW = T_QOS__WIDTH + 1;
  localparam int unsigned IdxW = T_ID___WIDTH + 1;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                  r_state;
  logic [T_ID___WIDTH-1:0] r_grant;
  logic [T_ID___WIDTH-1:0] r_rr_ptr;
  logic [T_QOS__WIDTH-1:0] r_qos;

  logic [STREAM_COUNT-1:0] w_urgent;
  logic [T_ID___WIDTH-1:0] w_winner;
  logic [T_ID___WIDTH-1:0] w_next_ptr;
  logic [T_ID___WIDTH-1:0] w_sel;
  logic [IdxW-1:0]         w_idx;
  logic [KeyW-1:0]         w_key;
  logic [KeyW-1:0]         w_best_key;
  logic                    w_found;
  logic                    w_any_valid;
  logic                    w_pkt_end;
  logic                    w_arb;

  assign w_any_valid = |bus.s_valid_in;
  assign w_arb       = (r_state == StIdle) && w_any_valid;
  assign w_pkt_end   = (r_state == StBusy) && bus.s_valid_in[r_grant] && bus.m_ready_in &&
                       bus.s_last_in[r_grant];
  assign w_next_ptr  = (r_grant == T_ID___WIDTH'(STREAM_COUNT - 1)) ? '0 : r_grant + 1'b1;

  // Scan from rr_ptr with wrap; only a strictly larger {urgent, qos} key displaces the current
  // pick, so the first stream in scan order wins a tie. Indices >= STREAM_COUNT never appear.
  always_comb begin
    w_found    = 1'b0;
    w_best_key = '0;
    w_winner   = '0;
    w_idx      = '0;
    w_sel      = '0;
    w_key      = '0;
    for (int k = 0; k < STREAM_COUNT; k++) begin
      w_idx = {1'b0, r_rr_ptr} + IdxW'(k);
      if (w_idx >= IdxW'(STREAM_COUNT)) begin
        w_idx = w_idx - IdxW'(STREAM_COUNT);
      end
      w_sel = w_idx[T_ID___WIDTH-1:0];
      w_key = {w_urgent[w_sel], bus.s_qos_in[w_sel]};
      if (bus.s_valid_in[w_sel] && (!w_found || (w_key > w_best_key))) begin
        w_found    = 1'b1;
        w_best_key = w_key;
        w_winner   = w_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_grant  <= '0;
      r_qos    <= '0;
      r_rr_ptr <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_any_valid) begin
            r_state <= StBusy;
            r_grant <= w_winner;
            r_qos   <= bus.s_qos_in[w_winner];
          end
        end
        StBusy: begin
          if (w_pkt_end) begin
            r_state  <= StIdle;
            r_rr_ptr <= w_next_ptr;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Zero-latency passthrough of the granted stream; id and QoS are the latched values.
  always_comb begin
    bus.s_ready_out = '0;
    bus.m_data_out  = '0;
    bus.m_last_out  = 1'b0;
    bus.m_valid_out = 1'b0;
    if (r_state == StBusy) begin
      bus.m_data_out           = bus.s_data_in[r_grant];
      bus.m_last_out           = bus.s_last_in[r_grant];
      bus.m_valid_out          = bus.s_valid_in[r_grant];
      bus.s_ready_out[r_grant] = bus.m_ready_in;
    end
  end

  assign bus.m_id_out  = r_grant;
  assign bus.m_qos_out = r_qos;

`ifdef STREAM_ARB_AGING_EN
  localparam logic [AGE_WIDTH-1:0] AgeMax   = '1;
  localparam logic [AGE_WIDTH-1:0] AgeLimit = AGE_WIDTH'(AGE_LIMIT);

  logic [STREAM_COUNT-1:0][AGE_WIDTH-1:0] r_age;

  always_comb begin
    w_urgent = '0;
    for (int i = 0; i < STREAM_COUNT; i++) begin
      w_urgent[i] = (r_age[i] >= AgeLimit);
    end
  end

  // Ages move only on an arbitration: winner clears, waiting losers count up and saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_age <= '0;
    end else if (w_arb) begin
      for (int i = 0; i < STREAM_COUNT; i++) begin
        if (T_ID___WIDTH'(i) == w_winner) begin
          r_age[i] <= '0;
        end else if (bus.s_valid_in[i] && (r_age[i] != AgeMax)) begin
          r_age[i] <= r_age[i] + 1'b1;
        end
      end
    end
  end
`else
  assign w_urgent = '0;

  // Aging parameters are accepted so both builds share one instantiation; nothing is built.
  if ((AGE_WIDTH == 0) && (AGE_LIMIT == 0)) begin : g_age_params_unused
  end
`endif

endmodule
